alu_ctl_issue: RTL and testbench

- Producer side of the 7-bit ALUctl interface. Decodes RV32I instruction fields into the ALUctl word consumed by the core ALU, and registers it for the execute stage.
- Sits between the decode stage (upstream valid/ready) and execute (downstream valid/ready).
- Output stage is a 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
- Supports pipeline flush and flags illegal encodings.

---
 rtl/alu_ctl_issue_pkg.sv | 59 +++++
 rtl/alu_ctl_decode.sv | 54 +++++
 rtl/alu_ctl_issue.sv | 75 +++++++
 tb/tb_alu_ctl_issue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_issue_pkg.sv
// Shared ALUctl encodings, RV32I opcode constants and the buffered entry type
// used by the ALUctl producer and its decode table.
package alu_ctl_issue_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_SRA   = 4'b0100;
  localparam logic [3:0] ALU_SLL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_XOR   = 4'b1000;
  localparam logic [3:0] ALU_CSRRW = 4'b1001;
  localparam logic [3:0] ALU_CSRRS = 4'b1010;
  localparam logic [3:0] ALU_CSRRC = 4'b1011;
  localparam logic [3:0] ALU_SLTU  = 4'b1111;

  localparam logic [2:0] BR_NONE = 3'b010;
  localparam logic [2:0] BR_EQ   = 3'b000;
  localparam logic [2:0] BR_NE   = 3'b001;
  localparam logic [2:0] BR_LT   = 3'b100;
  localparam logic [2:0] BR_GE   = 3'b101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] ILLEGAL_CTL_DEF = 7'b0100000;

  typedef struct packed {
    logic [6:0] aluctl;
    logic       illegal;
  } alu_entry_t;

  // Register-register arithmetic; alt selects SUB for 000 and SRA for 101.
  function automatic logic [3:0] alu_arith(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    unique case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational RV32I field decode into {ALUctl, illegal}.
// Zero latency; no state, so no backpressure.
module alu_ctl_decode
  import alu_ctl_issue_pkg::*;
#(
  parameter logic [6:0] ILLEGAL_CTL = ILLEGAL_CTL_DEF
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [6:0] aluctl,
  output logic       illegal
);

  logic [2:0] br;
  logic [3:0] op;
  logic       bad;

  always_comb begin
    br  = BR_NONE;
    op  = ALU_ADD;
    bad = 1'b0;
    unique case (opcode)
      OPC_OP:     op = alu_arith(funct3, funct7b5);
      // Immediate forms have no SUB; bit 30 is part of the immediate except for shifts.
      OPC_OP_IMM: op = (funct3 == 3'b000) ? ALU_ADD : alu_arith(funct3, funct7b5);
      OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LUI: op = ALU_ADD;
      OPC_BRANCH: begin
        unique case (funct3)
          3'b000:  begin br = BR_EQ; op = ALU_SUB;  end
          3'b001:  begin br = BR_NE; op = ALU_SUB;  end
          3'b100:  begin br = BR_LT; op = ALU_SLT;  end
          3'b101:  begin br = BR_GE; op = ALU_SLT;  end
          3'b110:  begin br = BR_LT; op = ALU_SLTU; end
          3'b111:  begin br = BR_GE; op = ALU_SLTU; end
          default: bad = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        unique case (funct3)
          3'b000:          op = ALU_ADD;
          3'b001, 3'b101:  op = ALU_CSRRW;
          3'b010, 3'b110:  op = ALU_CSRRS;
          3'b011, 3'b111:  op = ALU_CSRRC;
          default:         bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    aluctl  = bad ? ILLEGAL_CTL : {br, op};
    illegal = bad;
  end

endmodule

// File: rtl/alu_ctl_issue.sv
// Decodes RV32I fields to ALUctl and queues them in a 2-entry skid buffer.
// One cycle accept-to-output; in_ready is registered and drops only when both entries are full.
module alu_ctl_issue
  import alu_ctl_issue_pkg::*;
#(
  parameter logic [6:0] ILLEGAL_CTL = ILLEGAL_CTL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] in_opcode,
  input  logic [2:0] in_funct3,
  input  logic       in_funct7b5,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_aluctl,
  output logic       out_illegal,
  input  logic       flush
);

  alu_entry_t dec_ent;
  alu_entry_t head_q, skid_q;
  logic [1:0] count_q, count_n;
  logic       in_ready_q;
  logic       accept, pop;

  alu_ctl_decode #(.ILLEGAL_CTL(ILLEGAL_CTL)) u_decode (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .aluctl   (dec_ent.aluctl),
    .illegal  (dec_ent.illegal)
  );

  // Held low while reset is asserted, high as soon as it releases.
  assign in_ready    = in_ready_q & rst_n;
  assign out_valid   = (count_q != 2'd0);
  assign out_aluctl  = head_q.aluctl;
  assign out_illegal = head_q.illegal;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    count_n = count_q;
    if (flush)
      count_n = 2'd0;
    else if (accept && !pop)
      count_n = count_q + 2'd1;
    else if (pop && !accept)
      count_n = count_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      head_q     <= '{aluctl: ILLEGAL_CTL, illegal: 1'b0};
      skid_q     <= '{aluctl: ILLEGAL_CTL, illegal: 1'b0};
    end else begin
      count_q    <= count_n;
      in_ready_q <= (count_n != 2'd2);
      if (!flush) begin
        if (accept && (count_q == 2'd0 || (pop && count_q == 2'd1)))
          head_q <= dec_ent;
        else if (accept && count_q == 2'd1)
          skid_q <= dec_ent;
        else if (pop && count_q == 2'd2)
          head_q <= skid_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctl_issue.sv
// Directed bench for alu_ctl_issue: decode vectors, skid fill/drain, flush and async reset.
module tb_alu_ctl_issue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_opcode;
  logic [2:0] in_funct3;
  logic       in_funct7b5;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_aluctl;
  logic       out_illegal;
  logic       flush;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_ctl_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct3   (in_funct3),
    .in_funct7b5 (in_funct7b5),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_aluctl  (out_aluctl),
    .out_illegal (out_illegal),
    .flush       (flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7);
    in_valid    = v;
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7b5 = f7;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streaming vectors: opcode, funct3, funct7b5, expected aluctl, expected illegal.
  localparam int NV = 10;
  logic [6:0] v_opc [NV] = '{7'b0110011, 7'b1100011, 7'b1100011, 7'b1100011, 7'b0010011,
                             7'b0010011, 7'b1110011, 7'b0110111, 7'b0000000, 7'b1110011};
  logic [2:0] v_f3  [NV] = '{3'b000, 3'b111, 3'b001, 3'b010, 3'b000,
                             3'b101, 3'b110, 3'b000, 3'b000, 3'b100};
  logic       v_f7  [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [6:0] v_exp [NV] = '{7'b0100110, 7'b1011111, 7'b0010110, 7'b0100000, 7'b0100010,
                             7'b0100100, 7'b0101010, 7'b0100010, 7'b0100000, 7'b0100000};
  logic       v_ill [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 1'b0);
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_aluctl", {25'd0, out_aluctl}, 32'h20);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back stream with out_ready high: occupancy holds at one entry.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, v_opc[i], v_f3[i], v_f7[i]);
      tick();
      chk($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_aluctl", i), {25'd0, out_aluctl}, {25'd0, v_exp[i]});
      chk($sformatf("stream%0d_illegal", i), {31'd0, out_illegal}, {31'd0, v_ill[i]});
      chk($sformatf("stream%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 7'd0, 3'd0, 1'b0);
    tick();
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Fill with out_ready low: ADD, XOR accepted, SLL refused.
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0);
    tick();
    chk("fill1_aluctl", {25'd0, out_aluctl}, 32'h22);
    chk("fill1_in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 7'b0110011, 3'b100, 1'b0);
    tick();
    chk("fill2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("fill2_hold", {25'd0, out_aluctl}, 32'h22);
    drive(1'b1, 7'b0110011, 3'b001, 1'b0);
    tick();
    chk("fill3_refused", {31'd0, in_ready}, 32'd0);
    chk("fill3_hold", {25'd0, out_aluctl}, 32'h22);
    chk("fill3_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("drain_xor", {25'd0, out_aluctl}, 32'h28);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("drain_sll", {25'd0, out_aluctl}, 32'h25);
    drive(1'b0, 7'd0, 3'd0, 1'b0);
    tick();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // Flush with two entries buffered and an instruction offered in the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0);
    tick();
    drive(1'b1, 7'b0110011, 3'b100, 1'b0);
    tick();
    chk("preflush_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 7'b0110011, 3'b000, 1'b1);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    drive(1'b1, 7'b0110011, 3'b110, 1'b0);
    tick();
    chk("postflush_or", {25'd0, out_aluctl}, 32'h21);
    drive(1'b0, 7'd0, 3'd0, 1'b0);
    tick();
    chk("postflush_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with a full buffer, between clock edges.
    out_ready = 1'b0;
    drive(1'b1, 7'b0110011, 3'b100, 1'b0);
    tick();
    drive(1'b1, 7'b0110011, 3'b001, 1'b0);
    tick();
    drive(1'b0, 7'd0, 3'd0, 1'b0);
    chk("prereset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", {31'd0, out_valid}, 32'd0);
    chk("areset_aluctl", {25'd0, out_aluctl}, 32'h20);
    chk("areset_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_reset_empty", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
